// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and header constants for the UART TX arbiter
// Contents: state_t (IDLE/HDR/DATA), HDR_BASE_DEF default header base, ID_W header ID field width.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;
  localparam logic [7:0] HDR_BASE_DEF = 8'hA0;
  localparam int ID_W = 3;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set bit after ptr (modulo NUM_REQ)
// Ports: req (request vector), ptr (last winner) -> sel (winner index), any (some request set).
module rr_pick import uart_pkg::*; #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    sel,
  output logic               any
);
  int best, d;
  always_comb begin
    best = NUM_REQ;
    d = 0;
    sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j - int'(ptr) - 1 + 2 * NUM_REQ) % NUM_REQ;
      if (req[j] && d < best) begin
        best = d;
        sel = ID_W'(j);
      end
    end
    any = |req;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one uart_tx between NUM_REQ byte streams
// Ports: clk, rst_n (async active-low); req_valid/req_data/req_last/req_ready per requester;
// tx_valid/tx_data/tx_ready toward uart_tx; grant_id (current/last grant), busy, overrun (sticky).
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int         NUM_REQ   = 4,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] HDR_BASE  = HDR_BASE_DEF,
  parameter int         MAX_BEATS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_ready,
  output logic [ID_W-1:0]      grant_id,
  output logic                 busy,
  output logic                 overrun
);
  localparam int GW = $clog2(NUM_REQ);
  state_t state, state_n;
  logic [ID_W-1:0] ptr, sel;
  logic [7:0] beats;
  logic any, fire, force_rel;
  logic [GW-1:0] g;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (.req(req_valid), .ptr(ptr), .sel(sel), .any(any));
  assign g = grant_id[GW-1:0];
  assign busy = state != IDLE;
  assign fire = tx_valid && tx_ready;
  // a non-final byte that fills the beat budget ends the grant
  assign force_rel = !req_last[g] && (beats + 8'd1 == 8'(MAX_BEATS));
  always_comb begin
    state_n = state;
    tx_valid = 1'b0;
    tx_data = '0;
    req_ready = '0;
    case (state)
      IDLE: state_n = any ? (HDR_EN ? HDR : DATA) : IDLE;
      HDR: begin
        tx_valid = 1'b1;
        tx_data = {HDR_BASE[7:3], grant_id};
        state_n = tx_ready ? DATA : HDR;
      end
      DATA: begin
        tx_valid = req_valid[g];
        tx_data = req_data[8*g +: 8];
        req_ready[g] = tx_ready;
        state_n = fire && (req_last[g] || force_rel) ? IDLE : DATA;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= ID_W'(NUM_REQ - 1);
      grant_id <= '0;
      beats <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) begin
        grant_id <= sel;
        ptr <= sel;
        beats <= '0;
      end
      if (state == DATA && fire) beats <= beats + 8'd1;
      if (state == DATA && fire && force_rel) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of two arbiter configurations against a packet-level model
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] rv[2], rl[2], rr[2];
  logic [31:0] rd[2];
  logic tr[2], tv[2], bz[2], ov[2];
  logic [7:0] td[2];
  logic [2:0] gi[2];
  int checks = 0, errors = 0;
  int own[2], ptr[2], lg[2], bt[2];
  bit hp[2], mov[2];
  logic [3:0] acc[2];
  logic ev;
  logic [7:0] ed;
  logic [3:0] er;
  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1'b1), .HDR_BASE(8'hA0), .MAX_BEATS(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_data(rd[0]), .req_last(rl[0]),
    .req_ready(rr[0]), .tx_valid(tv[0]), .tx_data(td[0]), .tx_ready(tr[0]),
    .grant_id(gi[0]), .busy(bz[0]), .overrun(ov[0]));
  uart_tx_arbiter #(.NUM_REQ(4), .HDR_EN(1'b0), .HDR_BASE(8'hA0), .MAX_BEATS(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_data(rd[1]), .req_last(rl[1]),
    .req_ready(rr[1]), .tx_valid(tv[1]), .tx_data(td[1]), .tx_ready(tr[1]),
    .grant_id(gi[1]), .busy(bz[1]), .overrun(ov[1]));

  task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h want %0h at %0t", n, i, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Packet-level model: owner (-1 when idle), header pending, data bytes taken this grant.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        own[i] = -1; ptr[i] = 3; lg[i] = 0; bt[i] = 0; hp[i] = 0; mov[i] = 0;
      end
      ev = 0; ed = 0; er = 0;
      if (own[i] >= 0 && hp[i]) begin
        ev = 1; ed = 8'hA0 | 8'(own[i]);
      end else if (own[i] >= 0) begin
        ev = rv[i][own[i]]; ed = rd[i][8*own[i] +: 8]; er = 4'(tr[i]) << own[i];
      end
      chk("tx_valid", i, tv[i], ev);
      chk("tx_data", i, td[i], ed);
      chk("req_ready", i, rr[i], er);
      chk("grant_id", i, gi[i], lg[i]);
      chk("busy", i, bz[i], own[i] >= 0);
      chk("overrun", i, ov[i], mov[i]);
      acc[i] = er & rv[i];
      if (rst_n) begin
        if (own[i] < 0) begin
          if (rv[i] != 0) begin
            for (int k = 4; k >= 1; k--) if (rv[i][(ptr[i] + k) % 4]) own[i] = (ptr[i] + k) % 4;
            ptr[i] = own[i]; lg[i] = own[i]; hp[i] = (i == 0); bt[i] = 0;
          end
        end else if (hp[i]) begin
          if (tr[i]) hp[i] = 0;
        end else if (rv[i][own[i]] && tr[i]) begin
          bt[i]++;
          if (rl[i][own[i]]) own[i] = -1;
          else if (bt[i] == ((i == 0) ? 4 : 64)) begin mov[i] = 1; own[i] = -1; end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin rv[i] = 0; rl[i] = 0; rd[i] = 0; tr[i] = 0; end
    step; step;
    chk("rst_tx_valid", 0, tv[0], 0);
    chk("rst_busy", 0, bz[0], 0);
    chk("rst_grant", 0, gi[0], 0);
    chk("rst_overrun", 0, ov[0], 0);
    rst_n = 1'b1;
    // strict rotation with all requesters holding single-byte packets
    rv[0] = 4'hF; rl[0] = 4'hF; rd[0] = 32'h44332211; tr[0] = 1;
    for (int p = 0; p < 5; p++) begin
      step;
      chk("rot_grant", p, gi[0], p % 4);
      chk("rot_hdr", p, td[0], 8'hA0 | 8'(p % 4));
      step;
      chk("rot_data", p, td[0], 8'h11 * ((p % 4) + 1));
      step;
      chk("rot_idle", p, bz[0], 0);
    end
    rv[0] = 0; rl[0] = 0;
    // forced release after four beats, then regrant with a fresh header
    step;
    rv[0] = 4'b0100; rd[0] = 32'h00770000;
    step;
    chk("ovr_hdr", 0, td[0], 8'hA2);
    repeat (5) step;
    chk("ovr_busy", 0, bz[0], 0);
    chk("ovr_flag", 0, ov[0], 1);
    step;
    chk("ovr_rehdr", 0, td[0], 8'hA2);
    rl[0] = 4'b0100;
    step; step;
    rv[0] = 0; rl[0] = 0;
    // granted requester stalls while another waits
    step;
    rv[0] = 4'b0001; rd[0] = 32'h10;
    step; step;
    rv[0] = 4'b1000;
    for (int c = 0; c < 10; c++) begin
      step;
      chk("hold_txv", c, tv[0], 0);
      chk("hold_grant", c, gi[0], 0);
    end
    rv[0] = 4'b1001; rl[0] = 4'b0001;
    step;
    rv[0] = 4'b1000; rl[0] = 0;
    step;
    chk("next_grant", 0, gi[0], 3);
    chk("next_hdr", 0, td[0], 8'hA3);
    rl[0] = 4'b1000;
    step; step;
    rv[0] = 0; rl[0] = 0;
    // two-byte packet from requester 1
    step;
    rv[0] = 4'b0010; rd[0] = 32'h4800;
    step;
    chk("p1_hdr", 0, td[0], 8'hA1);
    chk("p1_grant", 0, gi[0], 1);
    step;
    chk("p1_b0", 0, td[0], 8'h48);
    chk("p1_ready", 0, rr[0], 4'b0010);
    step;
    rd[0] = 32'h4900; rl[0] = 4'b0010;
    #1 chk("p1_b1", 0, td[0], 8'h49);
    step;
    rv[0] = 0; rl[0] = 0;
    #1 chk("p1_busy", 0, bz[0], 0);
    chk("p1_grant_end", 0, gi[0], 1);
    // asynchronous reset in the middle of a packet
    rv[0] = 4'b0010; rd[0] = 32'h5500;
    step; step;
    #1 rst_n = 1'b0;
    #1 chk("ar_txv", 0, tv[0], 0);
    chk("ar_busy", 0, bz[0], 0);
    chk("ar_grant", 0, gi[0], 0);
    chk("ar_ready", 0, rr[0], 0);
    chk("ar_ovr", 0, ov[0], 0);
    rv[0] = 4'b0011; rl[0] = 4'b0011;
    step;
    rst_n = 1'b1;
    step;
    chk("ar_first", 0, gi[0], 0);
    rv[0] = 4'b0001;
    step; step;
    rv[0] = 0; rl[0] = 0;
    // no-header instance stalled by uart_tx
    rv[1] = 4'b0001; rd[1] = 32'h5A; rl[1] = 4'b0001; tr[1] = 0;
    step;
    for (int c = 0; c < 20; c++) begin
      chk("stall_txv", c, tv[1], 1);
      chk("stall_data", c, td[1], 8'h5A);
      chk("stall_ready", c, rr[1], 0);
      step;
    end
    tr[1] = 1;
    #1 chk("stall_acc", 0, rr[1], 4'b0001);
    step;
    rv[1] = 0; rl[1] = 0; tr[1] = 0;
    #1 chk("stall_busy", 0, bz[1], 0);
    // random traffic; requesters hold a byte until it is accepted or they give up
    repeat (3000) begin
      step;
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (acc[i][j] || !rv[i][j]) begin
            rv[i][j] = $urandom_range(0, 3) != 0;
            rd[i][8*j +: 8] = 8'($urandom);
            rl[i][j] = $urandom_range(0, 3) == 0;
          end else if ($urandom_range(0, 15) == 0) rv[i][j] = 0;
        end
        tr[i] = $urandom_range(0, 2) != 0;
      end
    end
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx instance between NUM_REQ byte-stream requesters, e.g. a status reporter and a debug echo path in tt_um_javibajocero_top.
- Arbitration is round-robin at packet granularity. A grant is held until the requester's last byte is accepted.
- An optional header byte carrying the requester ID is sent at the start of each packet.
- Sits directly in front of uart_tx and drives its tx_valid/tx_data handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HDR_EN, 1, 1 = send header byte (HDR_BASE | id) before each packet.
- HDR_BASE, 8'hA0, header base value; low 3 bits are replaced by the ID.
- MAX_BEATS, 64, maximum data bytes per grant before forced release (1..255).

Ports:
- clk, input, 1, system clock (same domain as uart_tx).
- rst_n, input, 1, asynchronous active-low reset.
- req_valid, input, NUM_REQ, per-requester byte valid.
- req_data, input, 8*NUM_REQ, per-requester byte; requester i uses bits [8i+7:8i].
- req_last, input, NUM_REQ, marks the final byte of a packet; qualified by req_valid.
- req_ready, output, NUM_REQ, byte accepted when req_valid[i] && req_ready[i].
- tx_valid, output, 1, to uart_tx tx_valid.
- tx_data, output, 8, to uart_tx tx_data.
- tx_ready, input, 1, from uart_tx; a byte transfers on a cycle with tx_valid && tx_ready.
- grant_id, output, 3, index of the current or last granted requester.
- busy, output, 1, high in HDR or DATA state.
- overrun, output, 1, sticky; set on a forced release, cleared only by reset.

Behaviour:
- Reset is asynchronous and active-low on rst_n. All state is clocked on the rising edge of clk.

Reset values:
- state=IDLE, tx_valid=0, tx_data=0, req_ready=0, grant_id=0, busy=0, overrun=0.
- Internal priority pointer ptr=NUM_REQ-1, so requester 0 has first priority after reset.

FSM states: IDLE, HDR, DATA.

IDLE:
- tx_valid=0 and req_ready=0.
- If any req_valid bit is set, select the first set bit scanning ptr+1, ptr+2, … modulo NUM_REQ.
- On the next clock: grant_id=sel, ptr=sel, beat counter=0.
- Next state is HDR if HDR_EN=1, otherwise DATA.
- Grant latency is 1 cycle from req_valid to the registered grant.

HDR:
- tx_valid=1 and tx_data = {HDR_BASE[7:3], grant_id}. req_ready=0.
- On tx_valid && tx_ready, go to DATA.
- The header is sent even if the granted requester has dropped req_valid.

DATA (combinational pass-through of the granted lane):
- tx_valid = req_valid[g], tx_data = lane g, req_ready[g] = tx_ready. All other req_ready bits are 0.
- On each accepted byte, the beat counter increments (8-bit).
- If the accepted byte has req_last[g]=1, go to IDLE.
- Otherwise, if beat counter+1 == MAX_BEATS, set overrun and go to IDLE (forced release).

Boundary conditions:
- Granted requester deasserts req_valid mid-packet: the grant is held indefinitely with tx_valid=0. No timeout.
- There is always one IDLE cycle between packets, including back-to-back packets from the same requester.
- Only one requester valid: it wins every arbitration.
- All requesters valid: grant order is strict rotation 0,1,2,3,0,…
- req_last with a single-byte packet: one beat, then return to IDLE.
- MAX_BEATS=1: every packet is a single beat. overrun is set only if req_last=0 on that beat.
- Requests arriving while busy are ignored until IDLE. Requests are not queued; they are held by the requester's valid.
- Reset asserted mid-packet: immediate return to reset values. A byte already handed to uart_tx is uart_tx's concern.
- tx_data must be stable while tx_valid=1 and tx_ready=0 (the HDR value is registered; in DATA the requester is required to hold).

Decomposition:
- Shared package uart_pkg holds the state enum (IDLE/HDR/DATA), the default HDR_BASE constant and the header ID field width.
- One natural sub-module: rr_pick. Purely combinational: inputs (req vector, ptr) → (sel index, any). Reusable by future RX/command arbiters.

Test Plan:
1. HDR_EN=1. Requester 1 sends 0x48, 0x49 (last). tx_ready pulses once per byte. Required serial order: 0xA1, 0x48, 0x49. busy falls 1 cycle after 0x49 is accepted. grant_id=1.
2. All four requesters hold 1-byte packets (last=1) continuously from reset. Required grant order: 0,1,2,3,0. Each packet is 2 bytes (header + data) with one IDLE cycle between packets.
3. MAX_BEATS=4. Requester 2 streams 6 bytes with last=0. After 4 data bytes: forced release and overrun=1. The requester is regranted later, and the new packet starts with header 0xA2.
4. Requester 0 drops req_valid for 10 cycles mid-packet while requester 3 is valid. Required: tx_valid=0 and grant stays at 0 until requester 0 resumes and finishes. Requester 3 is granted next.
5. Assert rst_n=0 during DATA with requester 1 granted. Required: outputs at reset values immediately (async). After release, requester 0 wins over simultaneous requester 1.
6. HDR_EN=0. Hold tx_ready=0 for 20 cycles while granted. Required: tx_valid=1 with stable tx_data, no req_ready. The byte is accepted on the first cycle tx_ready=1.
